comma_align: RTL and testbench
==============================

COMMA_ALIGN -- requirements
Module: comma_align

Interface
REQ-001 Parameter LOCK_COMMAS, default 3: consecutive in-phase commas needed to reach LOCKED (range 1..15).
REQ-002 Parameter LOSS_COMMAS, default 4: consecutive out-of-phase commas that drop LOCKED (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 enable  input  1  bit-strobe; serial_in sampled only when high.
REQ-006 serial_in  input  1  recovered 8b/10b line bit, first-transmitted bit (a) first.
REQ-007 encoded_val  output  10  aligned symbol, bit a at [9] ... bit j at [0]; feeds the 10b/8b decoder input of the same name.
REQ-008 valid  output  1  one-cycle pulse, encoded_val holds a new aligned symbol.
REQ-009 locked  output  1  high while state is LOCKED.
REQ-010 comma  output  1  qualifies valid; high when the emitted symbol contains a comma.

Function
REQ-011 10-bit shift register sr SHALL shift on each enable-high cycle as sr <= {sr[8:0], serial_in}; it SHALL hold when enable is low.
REQ-012 Comma detect SHALL be sr_next[9:3] == 7'b0011111 or 7'b1100000, evaluated on the post-shift value in enable-high cycles only.
REQ-013 Phase counter bit_cnt (0..9) SHALL increment per enable-high cycle, wrap 9->0; boundary = cycle in which bit_cnt==9.
REQ-014 States: UNLOCKED, ACQUIRE, LOCKED; reset state UNLOCKED.
REQ-015 UNLOCKED: comma detect SHALL force bit_cnt to 0 next, emit the symbol, set good_cnt=1, go to ACQUIRE (LOCK_COMMAS==1 goes straight to LOCKED); no valid otherwise.
REQ-016 ACQUIRE: comma on boundary SHALL increment good_cnt; reaching LOCK_COMMAS SHALL enter LOCKED and clear bad_cnt.
REQ-017 ACQUIRE: comma off boundary SHALL re-align (bit_cnt forced to 0 next), emit that symbol, and set good_cnt=1.
REQ-018 LOCKED: comma on boundary SHALL clear bad_cnt; comma off boundary SHALL increment bad_cnt without re-aligning; reaching LOSS_COMMAS SHALL enter UNLOCKED, clear counters, and drop locked.
REQ-019 In ACQUIRE and LOCKED every boundary SHALL emit: encoded_val <= sr_next, valid high for exactly the next clock cycle (latency 1 clk after the 10th bit sample).
REQ-020 comma SHALL be high with valid iff the emitted symbol matched REQ-012; low whenever valid is low.
REQ-021 encoded_val SHALL hold its last value between valid pulses; valid SHALL be low in any cycle following an enable-low cycle.
REQ-022 good_cnt and bad_cnt SHALL saturate and never wrap.

Reset
REQ-023 On rst high at a clock edge: sr=0, bit_cnt=0, good_cnt=0, bad_cnt=0, state UNLOCKED, encoded_val=0, valid=0, locked=0, comma=0.
REQ-024 rst SHALL dominate enable; reset mid-symbol SHALL discard the partial symbol, no valid emitted.

Configuration
REQ-025 Macro COMMA_ALIGN_STATS_EN defined: port realign_cnt output 16 SHALL exist; increments on every re-alignment (REQ-015, REQ-017) and every LOCKED->UNLOCKED transition; saturates at 16'hFFFF; reset 0.
REQ-026 Macro undefined: no realign_cnt port or counter logic; all other behaviour identical.

Verification
REQ-027 Reset, then stream K28.5 RD- (0011111010) continuously with enable=1 -> first valid 1 clk after 10th bit, encoded_val=10'h0FA, comma=1; locked rises after the 3rd comma.
REQ-028 Locked stream, insert 3 bit slip (extra bits) then K28.5 at new phase x4 -> bad_cnt reaches 4, locked=0, next comma re-aligns; realign_cnt increments by 2 with macro.
REQ-029 Locked, data symbol D21.5 (1010101010) between commas -> valid, encoded_val=10'h2AA, comma=0.
REQ-030 Toggle enable 1-0-1 per cycle over a locked stream -> same symbol sequence as continuous enable, valid pulses only after enable-high boundary cycles.
REQ-031 Assert rst after 5 bits of a symbol in LOCKED -> all outputs 0 next cycle, state UNLOCKED, no valid until a new comma.
REQ-032 In ACQUIRE (good_cnt=2), comma one bit off phase -> realign, good_cnt=1, locked stays 0.

Source files
------------

// File: rtl/comma_align.sv
// comma_align: serial 8b/10b comma detector and symbol aligner.
// Shifts in one line bit per enable strobe, hunts for K28.x comma patterns,
// aligns the 10-bit symbol boundary to them, and emits aligned symbols once
// acquisition has started. Lock is declared after LOCK_COMMAS consecutive
// in-phase commas and dropped after LOSS_COMMAS consecutive out-of-phase ones.
// Optional feature: define COMMA_ALIGN_STATS_EN to add the 16-bit
// saturating realign_cnt output (re-alignments plus lock losses).
module comma_align #(
    parameter int LOCK_COMMAS = 3,
    parameter int LOSS_COMMAS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       serial_in,
    output logic [9:0] encoded_val,
    output logic       valid,
    output logic       locked,
    output logic       comma
`ifdef COMMA_ALIGN_STATS_EN
    ,
    output logic [15:0] realign_cnt
`endif
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_COMMAS);
    localparam logic [3:0] LOSS_TGT = 4'(LOSS_COMMAS);

    // Saturating 4-bit increment for the comma run counters.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic [9:0] sr_q, sr_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] good_cnt_q, good_cnt_d;
    logic [3:0] bad_cnt_q, bad_cnt_d;
    logic [1:0] state_q, state_d;
    logic [9:0] encoded_val_q, encoded_val_d;
    logic       valid_q, valid_d;
    logic       comma_q, comma_d;

    logic [9:0] sr_next;
    logic       comma_det;
    logic       boundary;
    logic [3:0] good_inc;
    logic [3:0] bad_inc;

    // Shift/detect datapath and the alignment state machine.
    always_comb begin
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        good_cnt_d    = good_cnt_q;
        bad_cnt_d     = bad_cnt_q;
        state_d       = state_q;
        encoded_val_d = encoded_val_q;
        valid_d       = 1'b0;
        comma_d       = 1'b0;

        sr_next   = {sr_q[8:0], serial_in};
        comma_det = (sr_next[9:3] == 7'b0011111) || (sr_next[9:3] == 7'b1100000);
        boundary  = (bit_cnt_q == 4'd9);
        good_inc  = sat_inc4(good_cnt_q);
        bad_inc   = sat_inc4(bad_cnt_q);

        if (enable) begin
            sr_d      = sr_next;
            bit_cnt_d = boundary ? 4'd0 : bit_cnt_q + 4'd1;

            case (state_q)
                ST_UNLOCKED: begin
                    // Any comma sets the symbol phase and starts acquisition.
                    if (comma_det) begin
                        bit_cnt_d     = 4'd0;
                        encoded_val_d = sr_next;
                        valid_d       = 1'b1;
                        comma_d       = 1'b1;
                        good_cnt_d    = 4'd1;
                        if (LOCK_TGT <= 4'd1) begin
                            state_d   = ST_LOCKED;
                            bad_cnt_d = 4'd0;
                        end else begin
                            state_d = ST_ACQUIRE;
                        end
                    end
                end

                ST_ACQUIRE: begin
                    if (comma_det && boundary) begin
                        encoded_val_d = sr_next;
                        valid_d       = 1'b1;
                        comma_d       = 1'b1;
                        good_cnt_d    = good_inc;
                        if (good_inc >= LOCK_TGT) begin
                            state_d   = ST_LOCKED;
                            bad_cnt_d = 4'd0;
                        end
                    end else if (comma_det) begin
                        // Off-phase comma while acquiring: adopt its phase.
                        bit_cnt_d     = 4'd0;
                        encoded_val_d = sr_next;
                        valid_d       = 1'b1;
                        comma_d       = 1'b1;
                        good_cnt_d    = 4'd1;
                    end else if (boundary) begin
                        encoded_val_d = sr_next;
                        valid_d       = 1'b1;
                    end
                end

                ST_LOCKED: begin
                    if (boundary) begin
                        encoded_val_d = sr_next;
                        valid_d       = 1'b1;
                        comma_d       = comma_det;
                        if (comma_det) begin
                            bad_cnt_d = 4'd0;
                        end
                    end else if (comma_det) begin
                        // Off-phase comma while locked: count it, keep phase.
                        bad_cnt_d = bad_inc;
                        if (bad_inc >= LOSS_TGT) begin
                            state_d    = ST_UNLOCKED;
                            good_cnt_d = 4'd0;
                            bad_cnt_d  = 4'd0;
                        end
                    end
                end

                default: begin
                    state_d = ST_UNLOCKED;
                end
            endcase
        end
    end

    // Register update with synchronous reset of all state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q          <= 10'd0;
            bit_cnt_q     <= 4'd0;
            good_cnt_q    <= 4'd0;
            bad_cnt_q     <= 4'd0;
            state_q       <= ST_UNLOCKED;
            encoded_val_q <= 10'd0;
            valid_q       <= 1'b0;
            comma_q       <= 1'b0;
        end else begin
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            good_cnt_q    <= good_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            state_q       <= state_d;
            encoded_val_q <= encoded_val_d;
            valid_q       <= valid_d;
            comma_q       <= comma_d;
        end
    end

    assign encoded_val = encoded_val_q;
    assign valid       = valid_q;
    assign comma       = comma_q;
    assign locked      = (state_q == ST_LOCKED);

`ifdef COMMA_ALIGN_STATS_EN
    logic [15:0] realign_cnt_q, realign_cnt_d;
    logic        realign_evt;

    // Count every phase adoption and every loss of lock, saturating.
    always_comb begin
        realign_evt = ((state_q == ST_UNLOCKED) && (state_d != ST_UNLOCKED))
                    || ((state_q == ST_ACQUIRE) && enable && comma_det && !boundary)
                    || ((state_q == ST_LOCKED) && (state_d == ST_UNLOCKED));
        realign_cnt_d = realign_cnt_q;
        if (realign_evt && (realign_cnt_q != 16'hFFFF)) begin
            realign_cnt_d = realign_cnt_q + 16'd1;
        end
    end

    // Statistics register.
    always_ff @(posedge clk) begin
        if (rst) begin
            realign_cnt_q <= 16'd0;
        end else begin
            realign_cnt_q <= realign_cnt_d;
        end
    end

    assign realign_cnt = realign_cnt_q;
`endif

endmodule

// File: tb/tb_comma_align.sv
// Testbench for comma_align: randomized and directed serial streams checked
// every cycle against a behavioural model built on a bit-history queue,
// plus literal expectations for the key scenarios.
module tb_comma_align;

    localparam int LOCK_N = 3;
    localparam int LOSS_N = 4;
    localparam logic [9:0] K285 = 10'b0011111010;
    localparam logic [9:0] D215 = 10'b1010101010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       serial_in = 1'b0;
    logic [9:0] encoded_val;
    logic       valid;
    logic       locked;
    logic       comma;
`ifdef COMMA_ALIGN_STATS_EN
    logic [15:0] realign_cnt;
`endif

    comma_align #(.LOCK_COMMAS(LOCK_N), .LOSS_COMMAS(LOSS_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .serial_in  (serial_in),
        .encoded_val(encoded_val),
        .valid      (valid),
        .locked     (locked),
        .comma      (comma)
`ifdef COMMA_ALIGN_STATS_EN
        ,
        .realign_cnt(realign_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    bit   hist[$];
    int   since_align;     // samples since the current symbol phase started
    int   m_mode;          // 0 hunting, 1 acquiring, 2 locked
    int   m_good, m_bad;
    int   m_realign;
    logic [9:0] exp_enc;
    logic exp_valid, exp_comma, exp_locked;

    function automatic logic [9:0] hist_word();
        logic [9:0] w = 10'd0;
        foreach (hist[i]) w = {w[8:0], hist[i]};
        return w;
    endfunction

    function automatic bit is_comma(input logic [9:0] w);
        return (w[9:3] == 7'h1F) || (w[9:3] == 7'h60);
    endfunction

    task automatic model_clk(input logic r, input logic e, input logic b);
        logic [9:0] w;
        bit c, on_b, emit;
        if (r) begin
            hist.delete();
            since_align = 0; m_mode = 0; m_good = 0; m_bad = 0; m_realign = 0;
            exp_enc = 10'd0; exp_valid = 1'b0; exp_comma = 1'b0; exp_locked = 1'b0;
            return;
        end
        exp_valid = 1'b0;
        exp_comma = 1'b0;
        if (!e) return;
        hist.push_back(b);
        if (hist.size() > 10) void'(hist.pop_front());
        w = hist_word();
        c = is_comma(w);
        since_align++;
        on_b = (since_align == 10);
        if (on_b) since_align = 0;
        emit = 1'b0;
        if (m_mode == 0) begin
            if (c) begin
                emit = 1; since_align = 0; m_good = 1;
                if (m_realign < 65535) m_realign++;
                if (LOCK_N <= 1) begin m_mode = 2; m_bad = 0; end
                else m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (c && on_b) begin
                emit = 1;
                if (m_good < 15) m_good++;
                if (m_good >= LOCK_N) begin m_mode = 2; m_bad = 0; end
            end else if (c) begin
                emit = 1; since_align = 0; m_good = 1;
                if (m_realign < 65535) m_realign++;
            end else if (on_b) emit = 1;
        end else begin
            if (on_b) begin
                emit = 1;
                if (c) m_bad = 0;
            end else if (c) begin
                if (m_bad < 15) m_bad++;
                if (m_bad >= LOSS_N) begin
                    m_mode = 0; m_good = 0; m_bad = 0;
                    if (m_realign < 65535) m_realign++;
                end
            end
        end
        if (emit) begin
            exp_valid = 1'b1;
            exp_enc   = w;
            exp_comma = c;
        end
        exp_locked = (m_mode == 2);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (valid !== exp_valid || comma !== exp_comma ||
                locked !== exp_locked || encoded_val !== exp_enc) begin
                errors++;
                $display("FAIL model t=%0t got v=%b c=%b l=%b enc=%h want v=%b c=%b l=%b enc=%h",
                         $time, valid, comma, locked, encoded_val,
                         exp_valid, exp_comma, exp_locked, exp_enc);
            end
`ifdef COMMA_ALIGN_STATS_EN
            checks++;
            if (realign_cnt !== 16'(m_realign)) begin
                errors++;
                $display("FAIL model_realign t=%0t got=%0d want=%0d", $time, realign_cnt, m_realign);
            end
`endif
        end
    end

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic b);
        rst = r; enable = e; serial_in = b;
        @(posedge clk);
        model_clk(r, e, b);
        @(negedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [9:0] s, input bit toggle);
        for (int i = 9; i >= 0; i--) begin
            step(1'b0, 1'b1, s[i]);
            if (toggle) step(1'b0, 1'b0, 1'($urandom));
        end
    endtask

    initial begin
`ifdef COMMA_ALIGN_STATS_EN
        logic [15:0] rc0;
`endif
        logic [9:0] partial;
        step(1'b1, 1'b1, 1'b1);
        chk_en = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        lit("reset_valid", 16'(valid), 16'h0);
        lit("reset_enc", 16'(encoded_val), 16'h0);
        lit("reset_locked", 16'(locked), 16'h0);
        lit("reset_comma", 16'(comma), 16'h0);

        // Continuous comma stream: first symbol, then lock on the third.
        send_sym(K285, 1'b0);
        lit("first_valid", 16'(valid), 16'h1);
        lit("first_enc", 16'(encoded_val), 16'h0FA);
        lit("first_comma", 16'(comma), 16'h1);
        lit("first_unlocked", 16'(locked), 16'h0);
        send_sym(K285, 1'b0);
        lit("second_unlocked", 16'(locked), 16'h0);
        send_sym(K285, 1'b0);
        lit("lock_after_3", 16'(locked), 16'h1);

        // Data symbol between commas.
        send_sym(D215, 1'b0);
        lit("data_valid", 16'(valid), 16'h1);
        lit("data_enc", 16'(encoded_val), 16'h2AA);
        lit("data_comma", 16'(comma), 16'h0);
        send_sym(K285, 1'b0);

        // Enable toggling over a locked stream.
        for (int i = 0; i < 3; i++) begin
            send_sym(K285, 1'b1);
            send_sym(D215, 1'b1);
        end
        lit("toggle_locked", 16'(locked), 16'h1);
        lit("toggle_enc", 16'(encoded_val), 16'h2AA);

        // Three-bit slip then commas at the new phase.
`ifdef COMMA_ALIGN_STATS_EN
        rc0 = realign_cnt;
`endif
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_sym(K285, 1'b0);
        lit("slip_still_locked", 16'(locked), 16'h1);
        send_sym(K285, 1'b0);
        lit("slip_lost", 16'(locked), 16'h0);
        send_sym(K285, 1'b0);
        lit("slip_realign_valid", 16'(valid), 16'h1);
        lit("slip_realign_comma", 16'(comma), 16'h1);
`ifdef COMMA_ALIGN_STATS_EN
        lit("slip_realign_cnt", realign_cnt - rc0, 16'd2);
`endif
        send_sym(K285, 1'b0);
        send_sym(K285, 1'b0);
        lit("relock", 16'(locked), 16'h1);

        // Acquire with two commas, then a one-bit-off comma.
        step(1'b1, 1'b0, 1'b0);
        send_sym(K285, 1'b0);
        send_sym(K285, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        send_sym(K285, 1'b0);
        lit("acq_slip_valid", 16'(valid), 16'h1);
        lit("acq_slip_locked", 16'(locked), 16'h0);
        send_sym(K285, 1'b0);
        lit("acq_good2_locked", 16'(locked), 16'h0);
        send_sym(K285, 1'b0);
        lit("acq_good3_locked", 16'(locked), 16'h1);

        // Reset in the middle of a locked symbol.
        partial = K285;
        for (int i = 9; i >= 5; i--) step(1'b0, 1'b1, partial[i]);
        step(1'b1, 1'b1, 1'b1);
        lit("midrst_valid", 16'(valid), 16'h0);
        lit("midrst_enc", 16'(encoded_val), 16'h0);
        lit("midrst_locked", 16'(locked), 16'h0);
        for (int i = 4; i >= 0; i--) step(1'b0, 1'b1, partial[i]);
        lit("midrst_no_valid", 16'(valid), 16'h0);
        send_sym(D215, 1'b0);
        lit("midrst_data_no_valid", 16'(valid), 16'h0);
        send_sym(K285, 1'b0);
        lit("midrst_new_comma", 16'(valid), 16'h1);

        // Randomized traffic.
        for (int n = 0; n < 1200; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 1) step(1'b1, 1'($urandom), 1'($urandom));
            else if (r < 25) send_sym(K285, ($urandom_range(0, 3) == 0));
            else if (r < 35) begin
                for (int k = 0; k < 4; k++) send_sym(K285, 1'b0);
            end else if (r < 50) send_sym(10'($urandom), ($urandom_range(0, 3) == 0));
            else step(1'b0, ($urandom_range(0, 4) != 0), 1'($urandom));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
